ieee754_to_fixed: RTL and testbench

//  Decodes an IEEE-754 single-precision word into an unsigned fixed-point value (OUT_W bits, FRAC_W fractional).
//  It is the return path of the team's fixed-to-float encoder.

---
 rtl/ieee754_to_fixed.sv | 180 ++++++++++++++++++
 tb/tb_ieee754_to_fixed.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ieee754_to_fixed.sv
// ieee754_to_fixed: iterative IEEE-754 single -> unsigned fixed-point decoder.
// One alignment shift per cycle, round-to-nearest-even, saturating result,
// valid/ready handshake on both sides.
module ieee754_to_fixed #(
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_float,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             flag_ovf,
    output logic             flag_neg,
    output logic             flag_nan,
    output logic             flag_inx
);
    // Mantissa register wide enough that a left shift never drops a bit.
    localparam int MW = 24 + OUT_W;
    localparam logic signed [10:0] FRAC_S = 11'(FRAC_W);
    localparam logic signed [10:0] OUT_S  = 11'(OUT_W);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ROUND, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [MW-1:0]     man_q, man_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic              left_q, left_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [OUT_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic              neg_q, neg_d;
    logic              nan_q, nan_d;
    logic              inx_q, inx_d;

    // Field split and shift-distance computation for the incoming word.
    logic               f_sign;
    logic [7:0]         f_exp;
    logic [22:0]        f_frac;
    logic signed [10:0] e_unb, s_val, s_abs;
    logic [4:0]         n_cnt;
    logic               inc;
    logic [MW:0]        sum;

    assign f_sign = in_float[31];
    assign f_exp  = in_float[30:23];
    assign f_frac = in_float[22:0];
    assign e_unb  = $signed({3'b000, f_exp}) - 11'sd127;
    assign s_val  = e_unb - 11'sd23 + FRAC_S;
    assign s_abs  = s_val[10] ? -s_val : s_val;
    // Beyond 26 right shifts the result is identical (mantissa 0, guard 0, sticky 1).
    assign n_cnt  = (s_abs > 11'sd26) ? 5'd26 : s_abs[4:0];

    // Round-to-nearest-even increment on the aligned integer.
    assign inc = guard_q & (sticky_q | man_q[0]);
    assign sum = {1'b0, man_q} + {{MW{1'b0}}, inc};

    // Next-state, datapath and result computation.
    always_comb begin
        state_d  = state_q;
        man_d    = man_q;
        guard_d  = guard_q;
        sticky_d = sticky_q;
        left_d   = left_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        nan_d    = nan_q;
        inx_d    = inx_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    data_d   = '0;
                    ovf_d    = 1'b0;
                    neg_d    = 1'b0;
                    nan_d    = 1'b0;
                    inx_d    = 1'b0;
                    man_d    = {{OUT_W{1'b0}}, 1'b1, f_frac};
                    guard_d  = 1'b0;
                    sticky_d = 1'b0;
                    left_d   = ~s_val[10];
                    cnt_d    = n_cnt;
                    if (f_exp == 8'hFF) begin
                        state_d = S_DONE;
                        if (f_frac != '0) begin
                            nan_d = 1'b1;
                        end else if (f_sign) begin
                            neg_d = 1'b1;
                        end else begin
                            data_d = '1;
                            ovf_d  = 1'b1;
                        end
                    end else if (f_exp == 8'h00) begin
                        // Zero or denormal: always below one LSB, sign ignored.
                        state_d = S_DONE;
                        inx_d   = |f_frac;
                    end else if (f_sign) begin
                        state_d = S_DONE;
                        neg_d   = 1'b1;
                    end else if ((e_unb + FRAC_S) >= OUT_S) begin
                        state_d = S_DONE;
                        data_d  = '1;
                        ovf_d   = 1'b1;
                    end else if (n_cnt != 5'd0) begin
                        state_d = S_SHIFT;
                    end else begin
                        state_d = S_ROUND;
                    end
                end
            end
            S_SHIFT: begin
                if (left_q) begin
                    man_d = man_q << 1;
                end else begin
                    man_d    = man_q >> 1;
                    guard_d  = man_q[0];
                    sticky_d = sticky_q | guard_q;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = S_ROUND;
            end
            S_ROUND: begin
                state_d = S_DONE;
                inx_d   = guard_q | sticky_q;
                if (|sum[MW:OUT_W]) begin
                    data_d = '1;
                    ovf_d  = 1'b1;
                end else begin
                    data_d = sum[OUT_W-1:0];
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any word in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            man_q    <= '0;
            guard_q  <= 1'b0;
            sticky_q <= 1'b0;
            left_q   <= 1'b0;
            cnt_q    <= '0;
            data_q   <= '0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
            nan_q    <= 1'b0;
            inx_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            man_q    <= man_d;
            guard_q  <= guard_d;
            sticky_q <= sticky_d;
            left_q   <= left_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
            nan_q    <= nan_d;
            inx_q    <= inx_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = data_q;
    assign flag_ovf  = ovf_q;
    assign flag_neg  = neg_q;
    assign flag_nan  = nan_q;
    assign flag_inx  = inx_q;
endmodule

// File: tb/tb_ieee754_to_fixed.sv
// Bench for ieee754_to_fixed: vector table, corner sequences, loopback sweep.
module tb_ieee754_to_fixed;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_float;
    logic        in_valid0, in_valid8;
    logic        in_ready0, in_ready8;
    logic        out_valid0, out_valid8;
    logic        out_ready0, out_ready8;
    logic [15:0] out_data0, out_data8;
    logic        ovf0, neg0, nan0, inx0;
    logic        ovf8, neg8, nan8, inx8;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  flags;   // {ovf, neg, nan, inx}
        int          lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        int          which;
        logic [31:0] f;
        logic [15:0] data;
        logic [3:0]  flags;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    ieee754_to_fixed #(.OUT_W(16), .FRAC_W(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_float(in_float), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_data(out_data0), .flag_ovf(ovf0), .flag_neg(neg0),
        .flag_nan(nan0), .flag_inx(inx0));

    ieee754_to_fixed #(.OUT_W(16), .FRAC_W(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .in_float(in_float), .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .flag_ovf(ovf8), .flag_neg(neg8),
        .flag_nan(nan8), .flag_inx(inx8));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, act, exp_v);
        end
    endtask

    function automatic logic [31:0] to_float(input int v);
        int p;
        logic [31:0] vv, f;
        p = 0;
        for (int i = 0; i < 32; i++) if (v[i]) p = i;
        vv = 32'(v) << (23 - p);
        f = {1'b0, 8'(127 + p), vv[22:0]};
        return f;
    endfunction

    // Drive one word, record expectation, wait (bounded) for result, compare, retire.
    task automatic run_word(input int which, input logic [31:0] f, input logic [15:0] ed,
                            input logic [3:0] ef, input int elat, input string nm);
        exp_t e, g;
        int   lat;
        bit   got;
        logic [15:0] d;
        logic [3:0]  fl;
        e.data = ed; e.flags = ef; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        in_float = f;
        if (which == 0) in_valid0 = 1'b1; else in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0; in_valid8 = 1'b0;
        lat = 1; got = 1'b0;
        while (!got && lat <= 64) begin
            if ((which == 0) ? out_valid0 : out_valid8) got = 1'b1;
            else begin
                @(posedge clk); #1;
                lat++;
            end
        end
        g = sb.pop_front();
        if (!got) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
        end else begin
            d  = (which == 0) ? out_data0 : out_data8;
            fl = (which == 0) ? {ovf0, neg0, nan0, inx0} : {ovf8, neg8, nan8, inx8};
            chk({nm, " lat"}, 32'(lat), 32'(g.lat));
            chk({nm, " data"}, {16'd0, d}, {16'd0, g.data});
            chk({nm, " flags"}, {28'd0, fl}, {28'd0, g.flags});
            if (which == 0) out_ready0 = 1'b1; else out_ready8 = 1'b1;
            @(posedge clk); #1;
            out_ready0 = 1'b0; out_ready8 = 1'b0;
            chk({nm, " retire"}, {31'd0, (which == 0) ? out_valid0 : out_valid8}, 32'd0);
        end
    endtask

    vec_t vt[$];
    int   v;

    initial begin
        reset = 1'b1; in_float = '0;
        in_valid0 = 1'b0; in_valid8 = 1'b0; out_ready0 = 1'b0; out_ready8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", {31'd0, in_ready0}, 32'd1);
        chk("rst out_valid", {31'd0, out_valid0}, 32'd0);
        chk("rst data/flags", {12'd0, out_data0, ovf0, neg0, nan0, inx0}, 32'd0);
        reset = 1'b0;

        vt.push_back('{0, 32'h42C80000, 16'h0064, 4'b0000, 19});
        vt.push_back('{0, 32'h3FC00000, 16'h0002, 4'b0001, 25});
        vt.push_back('{0, 32'h40200000, 16'h0002, 4'b0001, 24});
        vt.push_back('{0, 32'h477FFF00, 16'hFFFF, 4'b0000, 10});
        vt.push_back('{0, 32'h477FFF80, 16'hFFFF, 4'b1001, 10});
        vt.push_back('{0, 32'h47800000, 16'hFFFF, 4'b1000, 1});
        vt.push_back('{0, 32'h7FC00000, 16'h0000, 4'b0010, 1});
        vt.push_back('{0, 32'hC2C80000, 16'h0000, 4'b0100, 1});
        vt.push_back('{0, 32'h80000000, 16'h0000, 4'b0000, 1});
        vt.push_back('{0, 32'h00000001, 16'h0000, 4'b0001, 1});
        vt.push_back('{0, 32'h7F800000, 16'hFFFF, 4'b1000, 1});
        vt.push_back('{0, 32'hFF800000, 16'h0000, 4'b0100, 1});
        vt.push_back('{0, 32'h3F000000, 16'h0000, 4'b0001, 26});
        vt.push_back('{0, 32'h3F000001, 16'h0001, 4'b0001, 26});
        vt.push_back('{0, 32'h3FFFFFFF, 16'h0002, 4'b0001, 25});
        vt.push_back('{0, 32'h20000000, 16'h0000, 4'b0001, 28});
        vt.push_back('{1, 32'h3FC00000, 16'h0180, 4'b0000, 17});
        vt.push_back('{1, 32'h437F0000, 16'hFF00, 4'b0000, 10});
        vt.push_back('{1, 32'h43800000, 16'hFFFF, 4'b1000, 1});

        foreach (vt[i])
            run_word(vt[i].which, vt[i].f, vt[i].data, vt[i].flags, vt[i].lat,
                     $sformatf("vec%0d", i));

        // Backpressure: result held stable, no acceptance while waiting or retiring.
        run_word(0, 32'h42C80000, 16'h0064, 4'b0000, 19, "bp_pre");
        @(negedge clk);
        in_float = 32'h42C80000; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        for (int k = 0; k < 30 && !out_valid0; k++) begin
            @(posedge clk); #1;
        end
        in_float = 32'h3F800000; in_valid0 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp valid", {31'd0, out_valid0}, 32'd1);
            chk("bp in_ready", {31'd0, in_ready0}, 32'd0);
            chk("bp data", {12'd0, out_data0, ovf0, neg0, nan0, inx0}, {12'd0, 16'h0064, 4'b0000});
            @(posedge clk); #1;
        end
        out_ready0 = 1'b1;
        @(posedge clk); #1;
        out_ready0 = 1'b0; in_valid0 = 1'b0;
        chk("bp retired", {30'd0, out_valid0, in_ready0}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            chk("bp no bypass", {30'd0, out_valid0, in_ready0}, 32'd1);
        end

        // Reset mid-SHIFT aborts the word.
        @(negedge clk);
        in_float = 32'h42C80000; in_valid0 = 1'b1;
        @(posedge clk); #1;
        in_valid0 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midshift busy", {31'd0, in_ready0}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst2 idle", {30'd0, in_ready0, out_valid0}, 32'd2);
        chk("rst2 data/flags", {12'd0, out_data0, ovf0, neg0, nan0, inx0}, 32'd0);
        begin
            int stray;
            stray = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (out_valid0) stray++;
            end
            chk("rst2 no stray", 32'(stray), 32'd0);
        end

        // Loopback sweep subset: small integers, edges, random.
        for (int i = 1; i <= 40; i++)
            run_word(0, to_float(i), 16'(i), 4'b0000, 25 - $clog2(i + 1) + 1, $sformatf("lb%0d", i));
        foreach (vt[i]) begin end
        for (int i = 0; i < 150; i++) begin
            int p;
            if (i == 0) v = 65535;
            else if (i == 1) v = 32768;
            else if (i == 2) v = 32767;
            else if (i == 3) v = 256;
            else v = int'($urandom_range(1, 65535));
            p = 0;
            for (int b = 0; b < 16; b++) if (v[b]) p = b;
            run_word(0, to_float(v), 16'(v), 4'b0000, 25 - p, $sformatf("lbr%0d", v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
